// File: rtl/inst_rom_reader.sv
// Fetch stage between the PC and decode: issues synchronous ROM reads and queues
// the returned words with their PC tags. Flushes on redirect and stops after HALT.
module inst_rom_reader #(
  parameter int AW = 10,
  parameter int IW = 9,
  parameter int DEPTH = 2,
  parameter logic [IW-1:0] HALT_OP = 9'h1FF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] ProgCtr,
  output logic          PcHold,
  input  logic          Redirect,
  output logic [AW-1:0] RomAddr,
  output logic          RomRdEn,
  input  logic [IW-1:0] RomData,
  output logic [IW-1:0] InstOut,
  output logic [AW-1:0] InstPc,
  output logic          InstValid,
  input  logic          InstReady,
  output logic          Done
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] mem_data [DEPTH];
  logic [AW-1:0] mem_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [AW-1:0] inflight_pc;

  logic          empty, pop, fifo_pop, bypass_pop, push, halt_pop, flush;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The word returning from the ROM this cycle is visible at the head when the
  // queue is empty, giving one-cycle fetch latency and full throughput.
  assign empty     = (count == '0);
  assign InstValid = !empty || inflight;

  always_comb begin
    InstOut = '0;
    InstPc  = '0;
    if (!empty) begin
      InstOut = mem_data[rd_ptr];
      InstPc  = mem_pc[rd_ptr];
    end else if (inflight) begin
      InstOut = RomData;
      InstPc  = inflight_pc;
    end
  end

  assign pop        = InstValid && InstReady;
  assign fifo_pop   = pop && !empty;
  assign bypass_pop = pop && empty;
  assign halt_pop   = pop && (InstOut == HALT_OP);
  assign flush      = Redirect || halt_pop;
  assign push       = inflight && !bypass_pop && !flush;

  // Occupancy includes the outstanding read so a returning word always has a slot.
  assign occ     = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign PcHold  = Done || (occ >= (CW+1)'(DEPTH));
  assign RomRdEn = !PcHold && !Redirect && !Reset;
  assign RomAddr = ProgCtr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      Done        <= 1'b0;
    end else if (!Done) begin
      if (flush) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        inflight <= 1'b0;
        if (halt_pop) Done <= 1'b1;
      end else begin
        if (push)     wr_ptr <= next_ptr(wr_ptr);
        if (fifo_pop) rd_ptr <= next_ptr(rd_ptr);
        count       <= count + CW'(push) - CW'(fifo_pop);
        inflight    <= RomRdEn;
        inflight_pc <= ProgCtr;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_data[wr_ptr] <= RomData;
      mem_pc[wr_ptr]   <= inflight_pc;
    end
  end

  // Occupancy accounting makes this impossible; catches a broken hold path.
  assert property (@(posedge Clk) disable iff (Reset)
    !(push && count == CW'(DEPTH) && !pop));

endmodule

// File: tb/tb_inst_rom_reader.sv
// Directed bench for inst_rom_reader: behavioural PC and synchronous ROM around the
// DUT, a cycle table for stream/backpressure/branch, and hand sequences for the rest.
module tb_inst_rom_reader;
  localparam int AW = 10;
  localparam int IW = 9;
  localparam int DEPTH = 2;
  localparam logic [IW-1:0] HALT = 9'h1FF;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] ProgCtr;
  logic          PcHold;
  logic          Redirect = 1'b0;
  logic [AW-1:0] RomAddr;
  logic          RomRdEn;
  logic [IW-1:0] RomData;
  logic [IW-1:0] InstOut;
  logic [AW-1:0] InstPc;
  logic          InstValid;
  logic          InstReady = 1'b0;
  logic          Done;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] rom [1024];
  logic [IW-1:0] rom_q;
  logic [AW-1:0] pc;
  logic [AW-1:0] target = 10'd40;

  inst_rom_reader #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .HALT_OP(HALT)) dut (
    .Clk(Clk), .Reset(Reset), .ProgCtr(ProgCtr), .PcHold(PcHold),
    .Redirect(Redirect), .RomAddr(RomAddr), .RomRdEn(RomRdEn), .RomData(RomData),
    .InstOut(InstOut), .InstPc(InstPc), .InstValid(InstValid),
    .InstReady(InstReady), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Program counter: jumps on a taken branch, otherwise advances unless held.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         pc <= '0;
    else if (Redirect) pc <= target;
    else if (!PcHold)  pc <= pc + 1'b1;
  end
  assign ProgCtr = pc;

  always_ff @(posedge Clk) begin
    if (RomRdEn) rom_q <= rom[RomAddr];
  end
  assign RomData = rom_q;

  typedef struct {
    logic          ready;
    logic          redir;
    logic          valid;
    logic [IW-1:0] out;
    logic [AW-1:0] ipc;
    logic          hold;
    logic          rden;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input bit r, input bit d, input bit v, input int o,
                              input int p, input bit h, input bit e);
    vec_t x;
    x.ready = r; x.redir = d; x.valid = v; x.out = IW'(o);
    x.ipc = AW'(p); x.hold = h; x.rden = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 1024; k++) rom[k] = IW'(k + 3);

    // ready, redirect, valid, out, pc, hold, rden; hold from cycle 2, branch at cycle 8
    tbl[0]  = mk(1, 0, 0,  0,  0, 0, 1);
    tbl[1]  = mk(1, 0, 1,  3,  0, 0, 1);
    tbl[2]  = mk(0, 0, 1,  4,  1, 0, 1);
    tbl[3]  = mk(0, 0, 1,  4,  1, 1, 0);
    tbl[4]  = mk(0, 0, 1,  4,  1, 1, 0);
    tbl[5]  = mk(1, 0, 1,  4,  1, 0, 1);
    tbl[6]  = mk(1, 0, 1,  5,  2, 0, 1);
    tbl[7]  = mk(1, 0, 1,  6,  3, 0, 1);
    tbl[8]  = mk(1, 1, 1,  7,  4, 0, 0);
    tbl[9]  = mk(1, 0, 0,  0,  0, 0, 1);
    tbl[10] = mk(1, 0, 1, 43, 40, 0, 1);
    tbl[11] = mk(1, 0, 1, 44, 41, 0, 1);

    #12;
    chk("rst valid", InstValid, 0);
    chk("rst done", Done, 0);
    chk("rst hold", PcHold, 0);
    chk("rst out", InstOut, 0);
    chk("rst pc", InstPc, 0);
    chk("rst rden", RomRdEn, 0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      InstReady = tbl[i].ready;
      Redirect  = tbl[i].redir;
      #1;
      chk($sformatf("c%0d valid", i), InstValid, tbl[i].valid);
      chk($sformatf("c%0d hold", i), PcHold, tbl[i].hold);
      chk($sformatf("c%0d rden", i), RomRdEn, tbl[i].rden);
      if (tbl[i].valid) begin
        chk($sformatf("c%0d out", i), InstOut, tbl[i].out);
        chk($sformatf("c%0d ipc", i), InstPc, tbl[i].ipc);
      end
      @(negedge Clk);
    end
    Redirect = 1'b0;

    // HALT at PC 6 in a free-running stream
    rom[6] = HALT;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    InstReady = 1'b1;
    repeat (7) @(negedge Clk);
    #1;
    chk("halt out", InstOut, HALT);
    chk("halt ipc", InstPc, 6);
    chk("halt done pre", Done, 0);
    @(negedge Clk);
    #1;
    chk("halt done", Done, 1);
    chk("halt valid", InstValid, 0);
    chk("halt hold", PcHold, 1);
    chk("halt rden", RomRdEn, 0);
    Redirect = 1'b1;
    #1;
    chk("halt redir rden", RomRdEn, 0);
    @(negedge Clk);
    Redirect = 1'b0;
    repeat (2) begin
      #1;
      chk("post redir done", Done, 1);
      chk("post redir valid", InstValid, 0);
      chk("post redir rden", RomRdEn, 0);
      @(negedge Clk);
    end
    #2;
    Reset = 1'b1;
    #1;
    chk("async done clr", Done, 0);
    chk("async hold clr", PcHold, 0);
    rom[6] = IW'(9);
    @(negedge Clk);
    Reset = 1'b0;

    // Fill to DEPTH, then redirect together with a pop of the full head
    InstReady = 1'b1;
    @(negedge Clk);
    InstReady = 1'b0;
    #1;
    chk("restart valid", InstValid, 1);
    chk("restart ipc", InstPc, 0);
    chk("restart out", InstOut, 3);
    @(negedge Clk);
    #1;
    chk("fill hold c2", PcHold, 1);
    @(negedge Clk);
    #1;
    chk("full hold", PcHold, 1);
    InstReady = 1'b1;
    Redirect = 1'b1;
    #1;
    chk("corner valid", InstValid, 1);
    chk("corner ipc", InstPc, 0);
    chk("corner out", InstOut, 3);
    chk("corner rden", RomRdEn, 0);
    chk("corner hold", PcHold, 0);
    @(negedge Clk);
    Redirect = 1'b0;
    InstReady = 1'b0;
    #1;
    chk("corner flushed", InstValid, 0);
    @(negedge Clk);
    #1;
    chk("corner tgt valid", InstValid, 1);
    chk("corner tgt ipc", InstPc, 40);
    chk("corner tgt out", InstOut, 43);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("refill hold", PcHold, 1);
    chk("refill ipc", InstPc, 40);

    // Asynchronous reset with the queue full
    #2;
    Reset = 1'b1;
    #1;
    chk("async valid", InstValid, 0);
    chk("async done", Done, 0);
    chk("async hold", PcHold, 0);
    chk("async out", InstOut, 0);
    @(negedge Clk);
    Reset = 1'b0;
    InstReady = 1'b1;
    @(negedge Clk);
    #1;
    chk("post async ipc", InstPc, 0);
    chk("post async out", InstOut, 3);
    chk("post async valid", InstValid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
